imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
Registered, parametrised immediate generator for the decode stage of the RV pipeline. It takes a 32-bit instruction word and a format select, and produces the XLEN-wide immediate one cycle later. It adds CSR-zimm and shift-amount formats, an unsupported-format flag, and an opaque tag carried alongside each immediate. A valid/ready handshake with a 2-entry elastic buffer gives full throughput under backpressure, and a flush input squashes wrong-path entries.

Parameters:
XLEN, 32, immediate output width; legal values are 32 and 64 only.
TAG_W, 8, width of the sideband tag (rd index, ROB id, etc.).

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
flush  input  1  squashes all buffered entries and any same-cycle input.
in_valid  input  1  an input is offered.
in_ready  output  1  the block can accept an input.
in_inst  input  32  instruction word.
in_imm_sel  input  3  format: 000 I, 001 S, 010 B, 011 U, 100 J, 101 Z, 110 SHAMT, 111 unsupported.
in_tag  input  TAG_W  sideband value, returned unchanged with the result.
out_valid  output  1  a result is presented.
out_ready  input  1  the consumer accepts the result.
out_imm  output  XLEN  generated immediate.
out_tag  output  TAG_W  tag of the presented result.
out_err  output  1  presented result came from format 111.

Behaviour:
- Formats. s(n) means inst[31] replicated n times. All formats are zero- or sign-extended to XLEN.
  - I: s, inst[31:20].
  - S: s, inst[31:25], inst[11:7].
  - B: s, inst[31], inst[7], inst[30:25], inst[11:8], 0.
  - U: s, inst[31:12], 12'b0. Bits above bit 31 are inst[31] when XLEN=64.
  - J: s, inst[31], inst[19:12], inst[20], inst[30:21], 0.
  - Z: zero-extended inst[19:15].
  - SHAMT: zero-extended inst[24:20] when XLEN=32; zero-extended inst[25:20] when XLEN=64.
  - 111: imm = 0 and err = 1. err = 0 for every other format.
- The immediate is computed combinationally at the input and stored already extended. The output comes only from registers; no combinational path runs from in_* to out_*.
- Storage: a main entry (drives out_*) plus one skid entry.
- Handshake:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - in_ready is a register equal to "skid entry empty". It does not depend combinationally on out_ready.
- Latency: an input accepted at edge N is presented at edge N+1 when the main entry is empty or is draining in that same cycle.
- Simultaneous accept and drain with the skid entry empty: the new input loads the main entry directly.
- Main entry full and not draining: an accepted input goes to the skid entry. in_ready falls on the next cycle.
- Main entry draining with the skid entry full: the skid entry moves into the main entry and in_ready rises on the next cycle.
- Ordering is strictly FIFO. No entry is duplicated or dropped unless flushed.
- Once asserted, out_valid and out_* hold stable until the transfer completes.
- Flush (sampled at the edge):
  - Both entries are invalidated and the same-cycle input is dropped, even if in_valid && in_ready.
  - Flush overrides a same-cycle output transfer. The consumer still sees that transfer as completed, so the consumer must also be flushing.
  - Cycle after flush: out_valid = 0, in_ready = 1.
- Reset (synchronous; overrides flush and all other activity):
  - out_valid = 0, out_imm = 0, out_tag = 0, out_err = 0, skid entry cleared, in_ready = 0 while rst is high.
  - in_ready = 1 on the first cycle after rst deasserts.
  - Reset in the middle of a transfer discards all entries.
- Data registers of invalid entries retain their last values, except under reset. Only out_valid qualifies out_*.

Test Plan:
1. XLEN=32, I-format, in_inst=0xFFF00093 (addi x1,x0,-1), out_ready=1 -> out_imm=0xFFFFFFFF one cycle later, out_err=0. Same stimulus with XLEN=64 -> out_imm=0xFFFFFFFFFFFFFFFF.
2. B-format in_inst=0xFE000EE3 (beq x0,x0,-4) -> out_imm=0xFFFFFFFC. U-format in_inst=0x123450B7 -> out_imm=0x12345000. XLEN=64, U-format in_inst=0x80000037 -> out_imm=0xFFFFFFFF80000000.
3. Z-format in_inst=0x000F9073 (rs1 field 31) -> out_imm=31. SHAMT with XLEN=64, in_inst[25:20]=6'h3F -> out_imm=63. Sel 111 -> out_imm=0, out_err=1.
4. Backpressure: out_ready=0, offer tags 1, 2, 3 on back-to-back cycles -> tags 1 and 2 accepted, in_ready=0 while tag 3 is held. Raise out_ready -> outputs appear as 1, 2, 3 in order, one per cycle, with no loss or duplication.
5. Flush with both entries full, and in_valid=1 on the same cycle -> next cycle out_valid=0 and in_ready=1. The same-cycle input never appears at the output.
6. Assert rst for 1 cycle mid-stream with out_ready toggling randomly -> all outputs read zero. in_ready=0 during rst and 1 on the first cycle after. A 1000-transaction random stream afterwards matches a reference model exactly.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RISC-V immediate generator behind a 2-entry elastic buffer
module imm_gen_pipe #(
  parameter int XLEN = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [2:0]       in_imm_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);
  logic [XLEN-1:0] imm, s_imm;
  logic [TAG_W-1:0] s_tag;
  logic err, s_err, s_valid, acc, drn, unused;
  assign unused = ^in_inst[6:0];
  assign acc = in_valid && in_ready;
  assign drn = out_valid && out_ready;
  assign err = in_imm_sel == 3'b111;
  assign imm =
    in_imm_sel == 3'b000 ? XLEN'($signed(in_inst[31:20])) :
    in_imm_sel == 3'b001 ? XLEN'($signed({in_inst[31:25], in_inst[11:7]})) :
    in_imm_sel == 3'b010 ? XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0})) :
    in_imm_sel == 3'b011 ? XLEN'($signed({in_inst[31:12], 12'b0})) :
    in_imm_sel == 3'b100 ? XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0})) :
    in_imm_sel == 3'b101 ? XLEN'(in_inst[19:15]) :
    in_imm_sel == 3'b110 ? (XLEN == 64 ? XLEN'(in_inst[25:20]) : XLEN'(in_inst[24:20])) :
    '0;
  always_ff @(posedge clk)
    if (rst) begin
      out_valid <= 1'b0;
      out_imm <= '0;
      out_tag <= '0;
      out_err <= 1'b0;
      s_valid <= 1'b0;
      s_imm <= '0;
      s_tag <= '0;
      s_err <= 1'b0;
      in_ready <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      s_valid <= 1'b0;
      in_ready <= 1'b1;
    end else if (drn || !out_valid) begin
      out_valid <= s_valid || acc;
      if (s_valid) begin
        out_imm <= s_imm;
        out_tag <= s_tag;
        out_err <= s_err;
      end else if (acc) begin
        out_imm <= imm;
        out_tag <= in_tag;
        out_err <= err;
      end
      s_valid <= 1'b0;
      in_ready <= 1'b1;
    end else if (acc) begin
      s_valid <= 1'b1;
      s_imm <= imm;
      s_tag <= in_tag;
      s_err <= err;
      in_ready <= 1'b0;
    end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: scoreboard bench driving XLEN=32 and XLEN=64 instances in lockstep
module tb_imm_gen_pipe;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_inst = '0;
  logic [2:0] in_imm_sel = '0;
  logic [7:0] in_tag = '0;
  logic rdy32, rdy64, v32, v64, err32, err64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [7:0] t32, t64;
  typedef struct {logic [63:0] imm; logic [7:0] tag; logic err;} exp_t;
  exp_t q32[$], q64[$], p32, p64;
  int n_cmp = 0, n_bad = 0;
  bit pend = 0, rst_prev = 1, acc = 0;
  always #5 clk = ~clk;
  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_inst(in_inst), .in_imm_sel(in_imm_sel), .in_tag(in_tag),
    .out_valid(v32), .out_ready(out_ready), .out_imm(imm32), .out_tag(t32), .out_err(err32));
  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_inst(in_inst), .in_imm_sel(in_imm_sel), .in_tag(in_tag),
    .out_valid(v64), .out_ready(out_ready), .out_imm(imm64), .out_tag(t64), .out_err(err64));
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic longint sext(longint v, int b);
    return v >= (longint'(1) << (b - 1)) ? v - (longint'(1) << b) : v;
  endfunction
  function automatic logic [63:0] ref_imm(logic [31:0] i, logic [2:0] s, bit x64);
    longint u, v;
    u = longint'(i);
    case (s)
      3'd0: v = sext((u >> 20) & 'hFFF, 12);
      3'd1: v = sext(((u >> 25) << 5) | ((u >> 7) & 31), 12);
      3'd2: v = sext(((u >> 31) << 12) | (((u >> 7) & 1) << 11) | (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1), 13);
      3'd3: v = sext(u & 'hFFFFF000, 32);
      3'd4: v = sext(((u >> 31) << 20) | (((u >> 12) & 255) << 12) | (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1), 21);
      3'd5: v = (u >> 15) & 31;
      3'd6: v = (u >> 20) & (x64 ? 63 : 31);
      default: v = 0;
    endcase
    return x64 ? 64'(v) : {32'd0, v[31:0]};
  endfunction
  task automatic step(bit v, logic [31:0] i, logic [2:0] s, logic [7:0] t, bit ordy, bit fl, bit rs,
                      bit ux, logic [63:0] x32, logic [63:0] x64, bit xe);
    @(posedge clk);
    #1;
    if (pend) begin
      q32.push_back(p32);
      q64.push_back(p64);
    end
    pend = 0;
    if (!rst_prev) begin
      chk("in_ready32", rdy32, q32.size() < 2);
      chk("in_ready64", rdy64, q64.size() < 2);
    end
    in_valid = v;
    in_inst = i;
    in_imm_sel = s;
    in_tag = t;
    out_ready = ordy;
    flush = fl;
    rst = rs;
    rst_prev = rs;
    acc = v && rdy32 && !fl && !rs;
    if (fl || rs) begin
      q32.delete();
      q64.delete();
    end
    if (acc) begin
      pend = 1;
      p32 = '{ux ? x32 : ref_imm(i, s, 0), t, ux ? xe : s == 3'd7};
      p64 = '{ux ? x64 : ref_imm(i, s, 1), t, ux ? xe : s == 3'd7};
    end
  endtask
  task automatic dir(logic [31:0] i, logic [2:0] s, logic [7:0] t, logic [63:0] x32, logic [63:0] x64, bit xe);
    step(1, i, s, t, 1, 0, 0, 1, x32, x64, xe);
  endtask
  task automatic rnd(int pv, int pr, int pf);
    step($urandom_range(0, 99) < pv, $urandom, 3'($urandom_range(0, 7)), 8'($urandom),
         $urandom_range(0, 99) < pr, $urandom_range(0, 99) < pf, 0, 0, 0, 0, 0);
  endtask
  bit hold = 0;
  logic [63:0] h32, h64;
  logic [7:0] ht;
  logic he;
  always @(negedge clk) begin
    if (hold) begin
      chk("hold_valid", {v32, v64}, 2'b11);
      chk("hold_imm32", imm32, h32);
      chk("hold_imm64", imm64, h64);
      chk("hold_tag", t32, ht);
      chk("hold_err", err32, he);
    end
    hold = 0;
    if (!rst && !flush && !rst_prev) begin
      chk("out_valid32", v32, q32.size() > 0);
      chk("out_valid64", v64, q64.size() > 0);
      if (v32 && out_ready && q32.size() > 0) begin
        exp_t e;
        e = q32.pop_front();
        chk("imm32", imm32, e.imm);
        chk("tag32", t32, e.tag);
        chk("err32", err32, e.err);
      end
      if (v64 && out_ready && q64.size() > 0) begin
        exp_t e;
        e = q64.pop_front();
        chk("imm64", imm64, e.imm);
        chk("tag64", t64, e.tag);
        chk("err64", err64, e.err);
      end
      if (v32 && !out_ready) begin
        hold = 1;
        h32 = 64'(imm32);
        h64 = imm64;
        ht = t32;
        he = err32;
      end
    end
  end
  initial begin
    int n;
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_valid", {v32, v64}, 2'b00);
    chk("rst_ready", {rdy32, rdy64}, 2'b00);
    dir(32'hFFF00093, 3'd0, 8'h11, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 0);
    dir(32'hFE000EE3, 3'd2, 8'h12, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 0);
    dir(32'h123450B7, 3'd3, 8'h13, 64'h12345000, 64'h12345000, 0);
    dir(32'h80000037, 3'd3, 8'h14, 64'h80000000, 64'hFFFFFFFF80000000, 0);
    dir(32'h000F9073, 3'd5, 8'h15, 64'd31, 64'd31, 0);
    dir(32'h03F00013, 3'd6, 8'h16, 64'd31, 64'd63, 0);
    dir(32'hFFFFFFFF, 3'd7, 8'h17, 64'd0, 64'd0, 1);
    dir(32'h00A12423, 3'd1, 8'h18, 64'd8, 64'd8, 0);
    dir(32'hFFDFF0EF, 3'd4, 8'h19, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 0);
    repeat (4) step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 32'h00100093, 3'd0, 8'd1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 32'h00200093, 3'd0, 8'd2, 0, 0, 0, 0, 0, 0, 0);
    step(1, 32'h00300093, 3'd0, 8'd3, 0, 0, 0, 0, 0, 0, 0);
    chk("bp_ready", {rdy32, acc}, 2'b00);
    step(1, 32'h00300093, 3'd0, 8'd3, 1, 0, 0, 0, 0, 0, 0);
    n = 0;
    while (!acc && n < 10) begin
      step(1, 32'h00300093, 3'd0, 8'd3, 1, 0, 0, 0, 0, 0, 0);
      n++;
    end
    if (!acc) begin
      n_bad++;
      $display("FAIL bp_accept: tag 3 never accepted");
    end
    repeat (4) step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("bp_drained", q32.size(), 0);
    step(1, 32'h00500093, 3'd0, 8'd5, 0, 0, 0, 0, 0, 0, 0);
    step(1, 32'h00600093, 3'd0, 8'd6, 0, 0, 0, 0, 0, 0, 0);
    step(1, 32'h00700093, 3'd0, 8'd7, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("flush_valid", {v32, v64}, 2'b00);
    chk("flush_ready", {rdy32, rdy64}, 2'b11);
    repeat (3) step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    repeat (30) rnd(80, 50, 0);
    step(1, $urandom, 3'd0, 8'hAA, $urandom_range(0, 1), 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, $urandom_range(0, 1), 0, 0, 0, 0, 0, 0);
    chk("rst2_valid", {v32, v64, err32, err64}, 4'b0000);
    chk("rst2_imm32", imm32, 0);
    chk("rst2_imm64", imm64, 0);
    chk("rst2_tag", {t32, t64}, 0);
    chk("rst2_ready", {rdy32, rdy64}, 2'b00);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("rst2_ready_after", {rdy32, rdy64}, 2'b11);
    n = 0;
    for (int c = 0; c < 20000 && n < 1000; c++) begin
      rnd(70, 60, 1);
      if (acc) n++;
    end
    if (n < 1000) begin
      n_bad++;
      $display("FAIL stream: only %0d of 1000 transactions accepted", n);
    end
    repeat (6) step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("final_drain32", q32.size(), 0);
    chk("final_drain64", q64.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
